// File: rtl/sw_led_ctrl.sv
// ---------------------------------------------------------------------------
// sw_led_ctrl
//   Switch conditioning and LED drive. Each raw switch is synchronised,
//   debounced and edge-detected. The debounced rising edges feed a per-channel
//   toggle register and a shared rise counter. A free-running blink phase
//   gates the debounced levels in blink mode. led_out is a registered
//   selection of one of four sources chosen by mode.
//
// Ports
//   clk        single clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   sw_in      raw asynchronous switch levels            [WIDTH]
//   mode       00 DIRECT, 01 TOGGLE, 10 BLINK, 11 COUNT  [2]
//   led_out    registered LED drive                      [WIDTH]
//   sw_stable  debounced switch levels                   [WIDTH]
//   sw_rise    one-cycle pulse after a debounced 0->1    [WIDTH]
// ---------------------------------------------------------------------------
module sw_led_ctrl #(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned BLINK_HALF_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led_out,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise
);

  // Counters are kept at least one bit wide so that a parameter value of 1
  // still yields legal hardware ($clog2(1) == 0).
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
  localparam int unsigned BL_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sync_s1;
  logic [WIDTH-1:0] sync_s2;
  logic [DB_W-1:0]  db_cnt [WIDTH];
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] toggle_q;
  logic [WIDTH-1:0] rise_cnt_q;
  logic [WIDTH-1:0] rise_pop;
  logic [BL_W-1:0]  blink_cnt;
  logic             blink_phase;
  logic [WIDTH-1:0] led_next;
  mode_e            mode_sel;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= sw_in;
      sync_s2 <= sync_s1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel debounce. The counter only runs while the synchronised level
  // disagrees with the accepted level; any agreement restarts it, so a glitch
  // shorter than DEBOUNCE_CYCLES mismatch cycles is never accepted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_stable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_s2[i] == sw_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sw_stable[i] <= sync_s2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Rising-edge pulse, one cycle after sw_stable goes high. Because stable_d
  // resets to 0, a switch held high through reset still produces a pulse.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= '0;
      sw_rise  <= '0;
    end else begin
      stable_d <= sw_stable;
      sw_rise  <= sw_stable & ~stable_d;
    end
  end

  // -------------------------------------------------------------------------
  // Toggle register and rise counter run in every mode. The popcount cannot
  // exceed WIDTH, which always fits in WIDTH bits.
  // -------------------------------------------------------------------------
  always_comb begin
    rise_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rise_pop = rise_pop + WIDTH'(sw_rise[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q   <= '0;
      rise_cnt_q <= '0;
    end else begin
      toggle_q   <= toggle_q ^ sw_rise;
      rise_cnt_q <= rise_cnt_q + rise_pop;
    end
  end

  // -------------------------------------------------------------------------
  // Blink phase: inverts every BLINK_HALF_PERIOD cycles, starting at 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // LED source selection, registered.
  // -------------------------------------------------------------------------
  assign mode_sel = mode_e'(mode);

  always_comb begin
    led_next = '0;
    case (mode_sel)
      MODE_DIRECT: led_next = sw_stable;
      MODE_TOGGLE: led_next = toggle_q;
      MODE_BLINK:  led_next = sw_stable & {WIDTH{blink_phase}};
      MODE_COUNT:  led_next = rise_cnt_q;
      default:     led_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else begin
      led_out <= led_next;
    end
  end

endmodule
